// File: rtl/pc_unit.sv
// Program counter and branch resolution: sequential step, relative branch, absolute jump, stall, halt.
// Optional taken-branch counter is enabled by defining PC_UNIT_BRANCH_COUNT_EN.
module pc_unit #(
    parameter int                  PC_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  OFF_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch,
    input  logic [OFF_WIDTH-1:0] br_offset,
    input  logic                 jump,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic                 halt,
    input  logic                 compres,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 fetch_valid,
    output logic                 taken,
    output logic                 halted,
    output logic [15:0]          branch_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_r, state_s;
    logic [PC_WIDTH-1:0]    pc_r, pc_s;
    logic [OFF_WIDTH-1:0]   offset_r, offset_s;
    logic                   taken_r, taken_s;
    logic                   halted_r;
    logic                   fetch_valid_s;
    logic [PC_WIDTH-1:0]    offset_ext_s;

    assign offset_ext_s = {{(PC_WIDTH-OFF_WIDTH){offset_r[OFF_WIDTH-1]}}, offset_r};

    // Next-state, next-pc and issue decision
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        offset_s      = offset_r;
        taken_s       = 1'b0;
        fetch_valid_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (stall) begin
                    fetch_valid_s = 1'b0;
                end else begin
                    fetch_valid_s = 1'b1;
                    if (halt) begin
                        state_s = ST_HALT;
                    end else if (jump) begin
                        pc_s = jump_target;
                    end else if (branch) begin
                        offset_s = br_offset;
                        state_s  = ST_RESOLVE;
                    end else begin
                        pc_s = pc_r + PC_ONE;
                    end
                end
            end
            ST_RESOLVE: begin
                // compres is only meaningful on the unstalled resolve cycle
                if (stall) begin
                    state_s = ST_RESOLVE;
                end else begin
                    state_s = ST_RUN;
                    if (compres) begin
                        pc_s    = pc_r + offset_ext_s;
                        taken_s = 1'b1;
                    end else begin
                        pc_s = pc_r + PC_ONE;
                    end
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // State, pc, offset and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= ST_RUN;
            pc_r     <= RESET_PC;
            offset_r <= {OFF_WIDTH{1'b0}};
            taken_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            offset_r <= offset_s;
            taken_r  <= taken_s;
            halted_r <= (state_s == ST_HALT);
        end
    end

`ifdef PC_UNIT_BRANCH_COUNT_EN
    logic [15:0] count_r;

    // Saturating taken-branch counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 16'd0;
        end else if (taken_s && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign branch_count = count_r;
`else
    assign branch_count = 16'd0;
`endif

    assign pc          = pc_r;
    assign fetch_valid = fetch_valid_s;
    assign taken       = taken_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios pinned by literals plus a randomized run
// checked every cycle against a behavioural model of the program-counter rules.
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [7:0]  br_offset = 8'h00;
    logic        jump = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic        halt = 1'b0;
    logic        compres = 1'b0;
    logic [15:0] pc;
    logic        fetch_valid;
    logic        taken;
    logic        halted;
    logic [15:0] branch_count;

    pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .branch(branch),
        .br_offset(br_offset), .jump(jump), .jump_target(jump_target),
        .halt(halt), .compres(compres), .pc(pc), .fetch_valid(fetch_valid),
        .taken(taken), .halted(halted), .branch_count(branch_count)
    );

    always #5 clock = ~clock;

    // Behavioural model: pc value, pending branch, halt flag, taken pulse, count
    logic [15:0] m_pc;
    logic        m_pend;
    logic [7:0]  m_off;
    logic        m_halt;
    logic        m_taken;
    int          m_count;
    logic        check_en = 1'b0;

    int checks = 0;
    int errors = 0;

`ifdef PC_UNIT_BRANCH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_count();
        return CNT_ON ? 16'(m_count) : 16'd0;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_pend = 1'b0; m_off = 8'h00; m_halt = 1'b0;
        m_taken = 1'b0; m_count = 0;
    endtask

    task automatic model_edge(input logic s, b, input logic [7:0] o, input logic j,
                              input logic [15:0] t, input logic h, c);
        logic signed [15:0] sx;
        m_taken = 1'b0;
        if (m_halt || s) begin
            // frozen
        end else if (m_pend) begin
            m_pend = 1'b0;
            if (c) begin
                sx = $signed(m_off);
                m_pc = m_pc + sx;
                m_taken = 1'b1;
                if (m_count < 65535) m_count++;
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end else if (h) begin
            m_halt = 1'b1;
        end else if (j) begin
            m_pc = t;
        end else if (b) begin
            m_pend = 1'b1;
            m_off = o;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic step(input logic s, b, input logic [7:0] o, input logic j,
                        input logic [15:0] t, input logic h, c);
        stall = s; branch = b; br_offset = o; jump = j; jump_target = t; halt = h; compres = c;
        @(posedge clock);
        model_edge(s, b, o, j, t, h, c);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        stall = 1'b0; branch = 1'b0; jump = 1'b0; halt = 1'b0; compres = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_taken", 32'(taken), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(branch_count), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        check_en = 1'b1;
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (check_en) begin
            check("pc", 32'(pc), 32'(m_pc));
            check("fetch_valid", 32'(fetch_valid), 32'(!m_halt && !m_pend && !stall));
            check("taken", 32'(taken), 32'(m_taken));
            check("halted", 32'(halted), 32'(m_halt));
            check("branch_count", 32'(branch_count), 32'(exp_count()));
        end
    end

    int halt_cycles;

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Sequential fetch after reset
        check("seq0", 32'(pc), 32'h0000);
        idle(); check("seq1", 32'(pc), 32'h0001);
        idle(); check("seq2", 32'(pc), 32'h0002);
        idle(); check("seq3", 32'(pc), 32'h0003);

        // Taken backward branch from 0x0010
        step(1'b0, 1'b0, 8'h00, 1'b1, 16'h0010, 1'b0, 1'b0);
        check("jmp10", 32'(pc), 32'h0010);
        step(1'b0, 1'b1, 8'hFC, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("br_hold", 32'(pc), 32'h0010);
        step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("br_taken_pc", 32'(pc), 32'h000C);
        check("br_taken_pulse", 32'(taken), 32'h1);
        check("br_taken_cnt", 32'(branch_count), CNT_ON ? 32'h1 : 32'h0);
        idle();
        check("taken_one_cycle", 32'(taken), 32'h0);

        // Not-taken branch from 0x0010
        step(1'b0, 1'b0, 8'h00, 1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hFC, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("br_nt_pc", 32'(pc), 32'h0011);
        check("br_nt_pulse", 32'(taken), 32'h0);
        check("br_nt_cnt", 32'(branch_count), CNT_ON ? 32'h1 : 32'h0);

        // Jump beats branch; then stalled resolve
        step(1'b0, 1'b1, 8'h05, 1'b1, 16'h0200, 1'b0, 1'b0);
        check("jmp_wins", 32'(pc), 32'h0200);
        step(1'b0, 1'b1, 8'h05, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("stall_hold", 32'(pc), 32'h0200);
        step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("stall_resolve", 32'(pc), 32'h0201);

        // Wrap-around
        step(1'b0, 1'b0, 8'h00, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        idle();
        check("wrap_inc", 32'(pc), 32'h0000);
        step(1'b0, 1'b0, 8'h00, 1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hFC, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("wrap_br", 32'(pc), 32'hFFFE);

        // Halt and freeze
        step(1'b0, 1'b0, 8'h00, 1'b1, 16'h0030, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("halted_rise", 32'(halted), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i[0], 8'h10, ~i[0], 16'h0123, 1'b0, 1'b1);
            check("halt_freeze", 32'(pc), 32'h0030);
        end

        // Reset while a branch is resolving
        do_reset();
        step(1'b0, 1'b1, 8'h05, 1'b0, 16'h0000, 1'b0, 1'b0);
        compres = 1'b1;
        do_reset();
        idle();
        check("rst_resolve_taken", 32'(taken), 32'h0);
        check("rst_resolve_pc", 32'(pc), 32'h0001);
        check("rst_resolve_cnt", 32'(branch_count), 32'h0);

        // Randomized run
        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_halt) halt_cycles++;
            if (halt_cycles > 6 || (m_pend && $urandom_range(0, 99) == 0)) begin
                halt_cycles = 0;
                do_reset();
            end else begin
                step(($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0),
                     8'($urandom),
                     ($urandom_range(0, 7) == 0),
                     16'($urandom),
                     ($urandom_range(0, 99) == 0),
                     1'($urandom));
            end
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
